// File: rtl/m68k_pkg.sv
// Shared definitions for the 68k-style interrupt-acknowledge master:
// level/vector types, IACK FSM encoding and autovector helper.
package m68k_pkg;

   localparam int unsigned LevelW = 3;
   localparam int unsigned VecW   = 8;

   typedef logic [LevelW-1:0] level_t;
   typedef logic [VecW-1:0]   vec_t;

   localparam vec_t   AvecBaseDef    = 8'h18;
   localparam vec_t   SpuriousVecDef = 8'h18;
   localparam level_t LevelNmi       = 3'd7;

   typedef enum logic [2:0] {
      StIdle,
      StAssert,
      StWait,
      StLatch,
      StRelease
   } iack_state_e;

   function automatic vec_t autovector(input vec_t base, input level_t lvl);
      return base + vec_t'(lvl);
   endfunction

endpackage

// File: rtl/ipl_filter.sv
// Synchronises the active-low ipl_n bus, accepts a new level only after two
// agreeing samples, and flags the rising edge of a filtered level 7.
module ipl_filter
   import m68k_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] ipl_n,
   output level_t     filtered,
   output logic       nmi_edge
);

   logic [2:0] meta_q, sync_q;
   level_t     level_now, samp_q, filt_q;
   logic       was_nmi_q;

   assign level_now = level_t'(~sync_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q    <= '1;
         sync_q    <= '1;
         samp_q    <= '0;
         filt_q    <= '0;
         was_nmi_q <= 1'b0;
      end else begin
         meta_q    <= ipl_n;
         sync_q    <= meta_q;
         samp_q    <= level_now;
         if (level_now == samp_q) filt_q <= level_now;
         was_nmi_q <= (filt_q == LevelNmi);
      end
   end

   assign filtered = filt_q;
   assign nmi_edge = (filt_q == LevelNmi) && !was_nmi_q;

endmodule

// File: rtl/m68k_iack_master.sv
// CPU-side interrupt request/acknowledge master: masks filtered IPL levels,
// requests the core, and runs the IACK cycle to a vectored/auto/spurious result.
module m68k_iack_master
   import m68k_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [7:0]  AVEC_BASE      = AvecBaseDef,
   parameter logic [7:0]  SPURIOUS_VEC   = SpuriousVecDef
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] ipl_n,
   input  logic [2:0] int_mask,
   output logic       irq_req,
   output logic [2:0] irq_level,
   input  logic       irq_grant,
   output logic       intr_cycle_n,
   output logic [2:0] iack_level,
   input  logic       dtack_n,
   input  logic       vpa_n,
   input  logic [7:0] data_in,
   output logic       vec_valid,
   output logic [7:0] vector,
   output logic       spurious
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   level_t      filt_level;
   logic        nmi_edge;
   logic [1:0]  term_meta_q, term_sync_q;
   logic        dtack_s, vpa_s;
   logic        nmi_q, req_d;
   level_t      lvl_d, irq_level_q, iack_q, iack_d;
   logic        irq_req_q;
   iack_state_e state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   vec_t        vec_q, vec_d;
   logic        spur_q, spur_d;

   ipl_filter u_ipl_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .ipl_n    (ipl_n),
      .filtered (filt_level),
      .nmi_edge (nmi_edge)
   );

   assign dtack_s = term_sync_q[1];
   assign vpa_s   = term_sync_q[0];

   // Level 7 is edge-triggered via the latch; a held level 7 alone never requests.
   always_comb begin
      req_d = 1'b0;
      lvl_d = '0;
      if (nmi_q || nmi_edge) begin
         req_d = 1'b1;
         lvl_d = LevelNmi;
      end else if (filt_level != LevelNmi && filt_level > int_mask) begin
         req_d = 1'b1;
         lvl_d = filt_level;
      end
   end

   always_comb begin
      state_d = state_q;
      iack_d  = iack_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      spur_d  = spur_q;
      unique case (state_q)
         StIdle: begin
            if (irq_req_q && irq_grant) begin
               iack_d  = irq_level_q;
               state_d = StAssert;
            end
         end
         StAssert: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            if (!vpa_s) begin
               vec_d   = autovector(AVEC_BASE, iack_q);
               spur_d  = 1'b0;
               state_d = StLatch;
            end else if (!dtack_s) begin
               vec_d   = data_in;
               spur_d  = 1'b0;
               state_d = StLatch;
            end else if (cnt_q == CntLast) begin
               vec_d   = SPURIOUS_VEC;
               spur_d  = 1'b1;
               state_d = StLatch;
            end
         end
         StLatch:   state_d = StRelease;
         StRelease: if (dtack_s && vpa_s) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term_meta_q <= '1;
         term_sync_q <= '1;
         nmi_q       <= 1'b0;
         irq_req_q   <= 1'b0;
         irq_level_q <= '0;
         state_q     <= StIdle;
         iack_q      <= '0;
         cnt_q       <= '0;
         vec_q       <= '0;
         spur_q      <= 1'b0;
      end else begin
         term_meta_q <= {dtack_n, vpa_n};
         term_sync_q <= term_meta_q;
         if (nmi_edge) nmi_q <= 1'b1;
         else if (state_q == StLatch && iack_q == LevelNmi) nmi_q <= 1'b0;
         irq_req_q   <= req_d;
         irq_level_q <= lvl_d;
         state_q     <= state_d;
         iack_q      <= iack_d;
         cnt_q       <= cnt_d;
         vec_q       <= vec_d;
         spur_q      <= spur_d;
      end
   end

   // Decoded from state so an async reset releases the strobe immediately.
   assign intr_cycle_n = !(state_q == StAssert || state_q == StWait);
   assign vec_valid    = (state_q == StLatch);
   assign irq_req      = irq_req_q;
   assign irq_level    = irq_level_q;
   assign iack_level   = iack_q;
   assign vector       = vec_q;
   assign spurious     = spur_q;

endmodule

// File: tb/tb_m68k_iack_master.sv
// Self-checking bench for m68k_iack_master: table-driven IACK transactions with a
// vector scoreboard, plus hand sequences for NMI edge, glitch, grant and reset cases.
module tb_m68k_iack_master;

   typedef enum int {TNone, TDtack, TVpa, TBoth, TTimeout} term_e;

   typedef struct {
      logic [2:0] ipl_n;
      logic [2:0] mask;
      logic       exp_req;
      logic [2:0] exp_lvl;
      term_e      term;
      logic [7:0] data;
   } vec_rec_t;

   typedef struct {
      logic [7:0] vec;
      logic       spur;
      int         t0;
      int         lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] ipl_n, int_mask, irq_level, iack_level;
   logic       irq_req, irq_grant, intr_cycle_n, dtack_n, vpa_n;
   logic [7:0] data_in, vector;
   logic       vec_valid, spurious;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t sb[$];
   vec_rec_t tbl[8];

   m68k_iack_master dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ipl_n        (ipl_n),
      .int_mask     (int_mask),
      .irq_req      (irq_req),
      .irq_level    (irq_level),
      .irq_grant    (irq_grant),
      .intr_cycle_n (intr_cycle_n),
      .iack_level   (iack_level),
      .dtack_n      (dtack_n),
      .vpa_n        (vpa_n),
      .data_in      (data_in),
      .vec_valid    (vec_valid),
      .vector       (vector),
      .spurious     (spurious)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      repeat (8) tick();
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) tick();
      check("scoreboard_drain", sb.size(), 0);
      sb.delete();
   endtask

   function automatic logic [7:0] exp_vector(input term_e t, input logic [2:0] lvl,
                                            input logic [7:0] d);
      case (t)
         TDtack:      return d;
         TVpa, TBoth: return 8'h18 + {5'b0, lvl};
         TTimeout:    return 8'h18;
         default:     return 8'h00;
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && vec_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_vec_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            check("vector", vector, e.vec);
            check("spurious", spurious, e.spur);
            check("strobe_released_at_valid", intr_cycle_n, 1);
            check("valid_latency", cyc - e.t0, e.lat);
         end
      end
   end

   initial begin
      logic seen;
      exp_t e;

      tbl[0] = '{3'b010, 3'd3, 1'b1, 3'd5, TDtack,   8'h51};
      tbl[1] = '{3'b100, 3'd3, 1'b0, 3'd3, TNone,    8'h00};
      tbl[2] = '{3'b100, 3'd2, 1'b1, 3'd3, TDtack,   8'h33};
      tbl[3] = '{3'b101, 3'd0, 1'b1, 3'd2, TVpa,     8'h00};
      tbl[4] = '{3'b001, 3'd0, 1'b1, 3'd6, TTimeout, 8'h00};
      tbl[5] = '{3'b110, 3'd0, 1'b1, 3'd1, TBoth,    8'h77};
      tbl[6] = '{3'b111, 3'd0, 1'b0, 3'd0, TNone,    8'h00};
      tbl[7] = '{3'b011, 3'd7, 1'b0, 3'd4, TNone,    8'h00};

      rst_n = 1'b0; ipl_n = 3'b111; int_mask = 3'd0; irq_grant = 1'b0;
      dtack_n = 1'b1; vpa_n = 1'b1; data_in = 8'h00;
      repeat (3) tick();
      check("rst_irq_req", irq_req, 0);
      check("rst_irq_level", irq_level, 0);
      check("rst_intr_cycle_n", intr_cycle_n, 1);
      check("rst_iack_level", iack_level, 0);
      check("rst_vec_valid", vec_valid, 0);
      check("rst_vector", vector, 0);
      check("rst_spurious", spurious, 0);
      rst_n = 1'b1;
      settle();

      for (int i = 0; i < 8; i++) begin
         ipl_n = tbl[i].ipl_n;
         int_mask = tbl[i].mask;
         settle();
         check($sformatf("rec%0d_irq_req", i), irq_req, tbl[i].exp_req);
         if (tbl[i].exp_req) begin
            check($sformatf("rec%0d_irq_level", i), irq_level, tbl[i].exp_lvl);
            irq_grant = 1'b1;
            tick();
            irq_grant = 1'b0;
            ipl_n = 3'b111;
            check($sformatf("rec%0d_strobe_low", i), intr_cycle_n, 0);
            check($sformatf("rec%0d_iack_level", i), iack_level, tbl[i].exp_lvl);
            case (tbl[i].term)
               TDtack: begin dtack_n = 1'b0; data_in = tbl[i].data; end
               TVpa:   vpa_n = 1'b0;
               TBoth:  begin dtack_n = 1'b0; vpa_n = 1'b0; data_in = tbl[i].data; end
               default: ;
            endcase
            e.vec  = exp_vector(tbl[i].term, tbl[i].exp_lvl, tbl[i].data);
            e.spur = (tbl[i].term == TTimeout);
            e.t0   = cyc;
            e.lat  = (tbl[i].term == TTimeout) ? 65 : 3;
            sb.push_back(e);
            wait_drain(100);
            check($sformatf("rec%0d_iack_held", i), iack_level, tbl[i].exp_lvl);
            dtack_n = 1'b1;
            vpa_n = 1'b1;
            settle();
            check($sformatf("rec%0d_req_cleared", i), irq_req, 0);
         end
         ipl_n = 3'b111;
         settle();
      end

      // Level 7: unmaskable, one request per rising edge of the filtered level.
      ipl_n = 3'b000; int_mask = 3'd7;
      settle();
      check("nmi_req", irq_req, 1);
      check("nmi_level", irq_level, 7);
      irq_grant = 1'b1;
      tick();
      irq_grant = 1'b0;
      vpa_n = 1'b0;
      e = '{8'h1F, 1'b0, cyc, 3};
      sb.push_back(e);
      wait_drain(20);
      vpa_n = 1'b1;
      settle();
      check("nmi_no_retrigger_held", irq_req, 0);
      ipl_n = 3'b111;
      settle();
      check("nmi_low_no_req", irq_req, 0);
      ipl_n = 3'b000;
      settle();
      check("nmi_re_edge_req", irq_req, 1);

      // Async reset in the middle of WAIT drops the strobe immediately.
      irq_grant = 1'b1;
      tick();
      irq_grant = 1'b0;
      tick();
      tick();
      check("wait_strobe_low", intr_cycle_n, 0);
      rst_n = 1'b0;
      #1;
      check("reset_releases_strobe", intr_cycle_n, 1);
      check("reset_clears_req", irq_req, 0);
      ipl_n = 3'b111; int_mask = 3'd0;
      tick();
      tick();
      rst_n = 1'b1;
      settle();

      // One-cycle glitch to level 7 must be filtered out.
      ipl_n = 3'b000;
      tick();
      ipl_n = 3'b111;
      seen = 1'b0;
      repeat (12) begin
         tick();
         seen = seen | irq_req;
      end
      check("glitch_no_req", seen, 0);

      // Grant with nothing pending is ignored.
      irq_grant = 1'b1;
      tick();
      irq_grant = 1'b0;
      check("idle_grant_ignored", intr_cycle_n, 1);
      tick();
      check("idle_grant_ignored_2", intr_cycle_n, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
